fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined CPU: it owns the PC register, the next-PC selection and the IF/ID segment register. It drives the instruction-memory address and hands the fetched instruction to ID. It consumes the `stall_pc`, `stall_if_id` and `flush_if_id` controls produced by the segment-hazard controller, plus the redirect request and targets resolved in EX. Saturating-free performance counters for cycles, stalls and flushes are kept for the debug bus.

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_seg_reg_if_id.sv | 27 ++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: next-PC select codes, bubble instruction, IF/ID bundle.
// Latency: none (types and constants only).
// Backpressure: none; stall/flush semantics live in the segment registers.
package fetch_stage_pkg;

    localparam logic [1:0] NPC_PCADD4 = 2'b00;
    localparam logic [1:0] NPC_PCJ    = 2'b01;
    localparam logic [1:0] NPC_JALR   = 2'b10;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcadd4;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    // Bubble seen by ID after reset or flush: a harmless nop at PC 0.
    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc     = 32'h0000_0000;
        b.pcadd4 = 32'h0000_0004;
        b.inst   = nop;
        b.valid  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_seg_reg_if_id.sv
// IF/ID segment register with hold and bubble-injection controls.
// Latency: one cycle from d to q.
// Backpressure: stall holds contents; flush overrides stall and loads the bubble.
module seg_reg_if_id
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= if_id_bubble(NOP);
        end else if (flush) begin
            q <= if_id_bubble(NOP);
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register and perf counters.
// Latency: im_addr is combinational from pc_if; fetched instruction reaches ID one cycle later.
// Backpressure: stall_pc/stall_if_id hold state; a redirect overrides stall_pc, flush overrides stall_if_id.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc,
    input  logic        stall_if_id,
    input  logic        flush_if_id,
    input  logic [1:0]  npc_sel_ex,
    input  logic [31:0] pc_j_ex,
    input  logic [31:0] pc_jalr_ex,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] pc_if,
    output logic [31:0] pc_id,
    output logic [31:0] pcadd4_id,
    output logic [31:0] inst_id,
    output logic        valid_id,
    output logic        misalign_sticky,
    output logic [31:0] perf_cycle,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    logic [31:0] pc_add4;
    logic [31:0] tgt_raw;
    logic [31:0] npc;
    logic        redirect;
    logic        misalign;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    assign pc_add4  = pc_if + 32'd4;
    assign im_addr  = pc_if;
    assign redirect = (npc_sel_ex != NPC_PCADD4);

    // jalr drops bit 0 before the alignment check, so only bit 1 can flag it.
    always_comb begin
        tgt_raw = pc_j_ex;
        if (npc_sel_ex == NPC_JALR) begin
            tgt_raw = pc_jalr_ex & 32'hFFFF_FFFE;
        end
        misalign = redirect && (tgt_raw[1:0] != 2'b00);
        npc      = redirect ? {tgt_raw[31:2], 2'b00} : pc_add4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_if <= RESET_PC;
        end else if (redirect || !stall_pc) begin
            pc_if <= npc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_sticky <= 1'b0;
            perf_cycle      <= 32'd0;
            perf_stall      <= 32'd0;
            perf_flush      <= 32'd0;
        end else begin
            if (misalign) begin
                misalign_sticky <= 1'b1;
            end
            perf_cycle <= perf_cycle + 32'd1;
            if (stall_pc && !redirect) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (flush_if_id) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end

    always_comb begin
        if_id_d.pc     = pc_if;
        if_id_d.pcadd4 = pc_add4;
        if_id_d.inst   = im_rdata;
        if_id_d.valid  = 1'b1;
    end

    seg_reg_if_id #(
        .NOP (NOP_INST)
    ) u_seg_reg_if_id (
        .clk   (clk),
        .rst   (rst),
        .stall (stall_if_id),
        .flush (flush_if_id),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign pc_id     = if_id_q.pc;
    assign pcadd4_id = if_id_q.pcadd4;
    assign inst_id   = if_id_q.inst;
    assign valid_id  = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage against an architectural fetch model.
// Stimulus pushes expected post-edge state; a monitor pops and compares after each edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_pc;
    logic        stall_if_id;
    logic        flush_if_id;
    logic [1:0]  npc_sel_ex;
    logic [31:0] pc_j_ex;
    logic [31:0] pc_jalr_ex;
    logic [31:0] im_rdata;
    logic [31:0] im_addr;
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] pcadd4_id;
    logic [31:0] inst_id;
    logic        valid_id;
    logic        misalign_sticky;
    logic [31:0] perf_cycle;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_id;
        logic [31:0] pcadd4_id;
        logic [31:0] inst_id;
        logic        valid;
        logic        sticky;
        logic [31:0] cyc;
        logic [31:0] stl;
        logic [31:0] fls;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   checks = 0;
    int   errors = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .flush_if_id     (flush_if_id),
        .npc_sel_ex      (npc_sel_ex),
        .pc_j_ex         (pc_j_ex),
        .pc_jalr_ex      (pc_jalr_ex),
        .im_rdata        (im_rdata),
        .im_addr         (im_addr),
        .pc_if           (pc_if),
        .pc_id           (pc_id),
        .pcadd4_id       (pcadd4_id),
        .inst_id         (inst_id),
        .valid_id        (valid_id),
        .misalign_sticky (misalign_sticky),
        .perf_cycle      (perf_cycle),
        .perf_stall      (perf_stall),
        .perf_flush      (perf_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    assign im_rdata = mem_f(im_addr);

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m.pc        = 32'h0000_0000;
        m.pc_id     = 32'h0000_0000;
        m.pcadd4_id = 32'h0000_0004;
        m.inst_id   = NOP;
        m.valid     = 1'b0;
        m.sticky    = 1'b0;
        m.cyc       = 32'd0;
        m.stl       = 32'd0;
        m.fls       = 32'd0;
    endtask

    // Called at a falling edge: apply controls, predict the state after the next rising edge.
    task automatic step(input logic spc, input logic sid, input logic fl, input logic [1:0] sel,
                        input logic [31:0] pj, input logic [31:0] pjalr);
        logic [31:0] tgt;
        logic        redir;
        stall_pc    = spc;
        stall_if_id = sid;
        flush_if_id = fl;
        npc_sel_ex  = sel;
        pc_j_ex     = pj;
        pc_jalr_ex  = pjalr;
        redir = (sel != 2'd0);
        tgt   = (sel == 2'd2) ? (pjalr & 32'hFFFF_FFFE) : pj;
        if (fl) begin
            m.pc_id = 0; m.pcadd4_id = 4; m.inst_id = NOP; m.valid = 0;
        end else if (!sid) begin
            m.pc_id = m.pc; m.pcadd4_id = m.pc + 4; m.inst_id = mem_f(m.pc); m.valid = 1;
        end
        if (redir && (tgt % 4 != 0)) m.sticky = 1'b1;
        if (redir)     m.pc = tgt - (tgt % 4);
        else if (!spc) m.pc = m.pc + 4;
        m.cyc = m.cyc + 1;
        if (spc && !redir) m.stl = m.stl + 1;
        if (fl) m.fls = m.fls + 1;
        sb.push_back(m);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("pc_if", pc_if, e.pc);
                cmp("im_addr", im_addr, e.pc);
                cmp("pc_id", pc_id, e.pc_id);
                cmp("pcadd4_id", pcadd4_id, e.pcadd4_id);
                cmp("inst_id", inst_id, e.inst_id);
                cmp("valid_id", {31'd0, valid_id}, {31'd0, e.valid});
                cmp("misalign_sticky", {31'd0, misalign_sticky}, {31'd0, e.sticky});
                cmp("perf_cycle", perf_cycle, e.cyc);
                cmp("perf_stall", perf_stall, e.stl);
                cmp("perf_flush", perf_flush, e.fls);
            end
        end
    end

    initial begin : stim
        logic        spc, sid, fl;
        logic [1:0]  sel;
        logic [31:0] pj, pjalr;
        rst = 1'b1; stall_pc = 0; stall_if_id = 0; flush_if_id = 0;
        npc_sel_ex = 0; pc_j_ex = 0; pc_jalr_ex = 0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp("rst_pc_if", pc_if, 32'h0);
        cmp("rst_inst_id", inst_id, NOP);
        cmp("rst_pcadd4_id", pcadd4_id, 32'h4);
        cmp("rst_valid_id", {31'd0, valid_id}, 32'd0);
        cmp("rst_perf_cycle", perf_cycle, 32'd0);
        rst = 1'b0;

        step(0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 2'd0, 0, 0);
        cmp("free_pc_if", pc_if, 32'h8);
        cmp("free_pc_id", pc_id, 32'h4);
        step(1, 1, 0, 2'd0, 0, 0);
        cmp("lu_pc_if", pc_if, 32'h8);
        cmp("lu_pc_id", pc_id, 32'h4);
        cmp("lu_perf_stall", perf_stall, 32'd1);
        step(0, 0, 0, 2'd0, 0, 0);
        cmp("lu_next_pc_if", pc_if, 32'hC);
        cmp("lu_next_pc_id", pc_id, 32'h8);
        cmp("free_perf_cycle", perf_cycle, 32'd4);

        step(0, 0, 1, 2'd1, 32'h40, 0);
        cmp("br_pc_if", pc_if, 32'h40);
        cmp("br_inst_id", inst_id, NOP);
        cmp("br_valid_id", {31'd0, valid_id}, 32'd0);
        cmp("br_perf_flush", perf_flush, 32'd1);

        step(0, 0, 1, 2'd2, 0, 32'h101);
        cmp("jalr101_pc_if", pc_if, 32'h100);
        cmp("jalr101_sticky", {31'd0, misalign_sticky}, 32'd0);
        step(0, 0, 1, 2'd2, 0, 32'h102);
        cmp("jalr102_pc_if", pc_if, 32'h100);
        cmp("jalr102_sticky", {31'd0, misalign_sticky}, 32'd1);

        step(1, 1, 1, 2'd1, 32'h80, 0);
        cmp("conf_pc_if", pc_if, 32'h80);
        cmp("conf_valid_id", {31'd0, valid_id}, 32'd0);
        cmp("conf_pc_id", pc_id, 32'h0);

        step(0, 0, 1, 2'd3, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 2'd0, 0, 0);
        cmp("wrap_pc_if", pc_if, 32'h0);
        cmp("wrap_pcadd4_id", pcadd4_id, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 2'd0, 0, 0);
        cmp("pre_arst_pc_if", pc_if, 32'h20);

        #2 rst = 1'b1;
        #1;
        cmp("arst_pc_if", pc_if, 32'h0);
        cmp("arst_perf_cycle", perf_cycle, 32'd0);
        cmp("arst_perf_stall", perf_stall, 32'd0);
        cmp("arst_perf_flush", perf_flush, 32'd0);
        cmp("arst_valid_id", {31'd0, valid_id}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            spc   = ($urandom % 4 == 0);
            sid   = spc ? 1'b1 : ($urandom % 8 == 0);
            sel   = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            fl    = (sel != 2'd0) ? ($urandom % 4 != 0) : ($urandom % 6 == 0);
            pj    = $urandom;
            pjalr = $urandom;
            if ($urandom % 2 == 0) begin
                pj    = pj & 32'hFFFF_FFFC;
                pjalr = pjalr & 32'hFFFF_FFFD;
            end
            step(spc, sid, fl, sel, pj, pjalr);
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
